// File: rtl/uart_rx.sv
// UART receiver: synchronises srx, frames start/data/parity/stop from a 16x baud tick,
// and maintains RBR plus the LSR receive flags (DR, OE, PE, FE, BI).
module uart_rx #(
   parameter int OVERSAMPLE  = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       baud_tick,
   input  logic       srx,
   input  logic [7:0] lcr,
   input  logic       read_rbr,
   input  logic       read_lsr,
   output logic [7:0] rbr_data,
   output logic       data_ready,
   output logic       overrun_err,
   output logic       parity_err,
   output logic       framing_err,
   output logic       break_int,
   output logic       rx_done,
   output logic       rx_busy,
   output logic [2:0] dbg_state,
   output logic [7:0] dbg_lcr
);
   localparam int TW = $clog2(OVERSAMPLE);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4,
      S_DONE   = 3'd5
   } state_t;

   state_t                 r_state, w_next;
   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_rxs_d;
   logic [TW-1:0]          r_tick_cnt;
   logic [2:0]             r_bit_cnt;
   logic [7:0]             r_lcr;
   logic [7:0]             r_shift;
   logic                   r_par_bit, r_pe_pend, r_fe_pend, r_bi_pend;
   logic                   w_rxs, w_fall, w_half, w_full, w_done, w_load;
   logic [2:0]             w_last_bit;
   logic [7:0]             w_data;

   assign w_rxs      = r_sync[SYNC_STAGES-1];
   assign w_fall     = r_rxs_d & ~w_rxs;
   assign w_half     = baud_tick && (r_tick_cnt == TW'(OVERSAMPLE/2 - 1));
   assign w_full     = baud_tick && (r_tick_cnt == TW'(OVERSAMPLE - 1));
   assign w_last_bit = {1'b1, r_lcr[1:0]};
   // Bits arrive LSB first into the top of the shift register, so right-justify by word length.
   assign w_data     = r_shift >> (2'd3 - r_lcr[1:0]);
   assign w_done     = (r_state == S_DONE);
   assign w_load     = w_done && (!data_ready || read_rbr);
   assign dbg_lcr    = r_lcr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync  <= '1;
         r_rxs_d <= 1'b1;
      end else begin
         r_sync  <= {r_sync[SYNC_STAGES-2:0], srx};
         r_rxs_d <= w_rxs;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (w_fall) w_next = S_START;
         S_START:  if (w_half) w_next = w_rxs ? S_IDLE : S_DATA;
         S_DATA:   if (w_full && (r_bit_cnt == w_last_bit)) w_next = r_lcr[3] ? S_PARITY : S_STOP;
         S_PARITY: if (w_full) w_next = S_STOP;
         S_STOP:   if (w_full) w_next = S_DONE;
         S_DONE:   w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   always_comb begin
      rx_done   = (r_state == S_DONE);
      rx_busy   = (r_state != S_IDLE);
      dbg_state = r_state;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tick_cnt <= '0;
      end else if (r_state == S_IDLE || w_next != r_state || w_full) begin
         r_tick_cnt <= '0;
      end else if (baud_tick) begin
         r_tick_cnt <= r_tick_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_lcr     <= '0;
         r_shift   <= '0;
         r_bit_cnt <= '0;
         r_par_bit <= 1'b0;
         r_pe_pend <= 1'b0;
         r_fe_pend <= 1'b0;
         r_bi_pend <= 1'b0;
      end else begin
         if (r_state == S_START && w_half && !w_rxs) begin
            r_lcr     <= lcr;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_par_bit <= 1'b0;
            r_pe_pend <= 1'b0;
            r_fe_pend <= 1'b0;
            r_bi_pend <= 1'b0;
         end
         if (r_state == S_DATA && w_full) begin
            r_shift   <= {w_rxs, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
         end
         // EPS=1 wants even total ones, EPS=0 odd.
         if (r_state == S_PARITY && w_full) begin
            r_par_bit <= w_rxs;
            r_pe_pend <= (^w_data) ^ w_rxs ^ ~r_lcr[4];
         end
         if (r_state == S_STOP && w_full) begin
            r_fe_pend <= ~w_rxs;
            r_bi_pend <= ~w_rxs && (w_data == 8'd0) && !r_par_bit;
         end
      end
   end

   // Host strobes clear next clock; a completion in the same cycle takes priority.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rbr_data    <= '0;
         data_ready  <= 1'b0;
         overrun_err <= 1'b0;
         parity_err  <= 1'b0;
         framing_err <= 1'b0;
         break_int   <= 1'b0;
      end else begin
         if (w_load) rbr_data <= w_data;
         if (w_load)        data_ready <= 1'b1;
         else if (read_rbr) data_ready <= 1'b0;
         overrun_err <= (overrun_err & ~read_lsr) | (w_done & ~w_load);
         parity_err  <= (parity_err  & ~read_lsr) | (w_done & r_pe_pend);
         framing_err <= (framing_err & ~read_lsr) | (w_done & r_fe_pend);
         break_int   <= (break_int   & ~read_lsr) | (w_done & r_bi_pend);
      end
   end
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed frame table, hand-built corner sequences, then random frames
// checked against a frame-level model of RBR and the LSR flags.
module tb_uart_rx;
   localparam int TICK_DIV = 4;
   localparam int BIT_CLKS = 16 * TICK_DIV;

   logic       clk = 1'b0;
   logic       rst, baud_tick, srx, read_rbr, read_lsr;
   logic [7:0] lcr;
   logic [7:0] rbr_data, dbg_lcr;
   logic       data_ready, overrun_err, parity_err, framing_err, break_int, rx_done, rx_busy;
   logic [2:0] dbg_state;

   int n_checks = 0;
   int n_errors = 0;
   int done_cnt = 0;
   int tick_div = 0;

   typedef struct {
      logic [7:0] lcr;
      logic [7:0] data;
      logic       par;
      logic       stop;
      logic [7:0] exp_rbr;
      logic       exp_pe;
      logic       exp_fe;
      logic       exp_bi;
   } vec_t;
   localparam int NV = 11;
   vec_t vecs[NV];

   uart_rx dut (
      .clk(clk), .rst(rst), .baud_tick(baud_tick), .srx(srx), .lcr(lcr),
      .read_rbr(read_rbr), .read_lsr(read_lsr), .rbr_data(rbr_data),
      .data_ready(data_ready), .overrun_err(overrun_err), .parity_err(parity_err),
      .framing_err(framing_err), .break_int(break_int), .rx_done(rx_done),
      .rx_busy(rx_busy), .dbg_state(dbg_state), .dbg_lcr(dbg_lcr)
   );

   // ---------------- clock / tick ----------------
   always #5 clk = ~clk;

   initial begin
      baud_tick = 1'b0;
      forever begin
         @(negedge clk);
         tick_div  = (tick_div == TICK_DIV - 1) ? 0 : tick_div + 1;
         baud_tick = (tick_div == 0);
      end
   end

   always @(negedge clk) if (rx_done === 1'b1) done_cnt++;

   // ---------------- scoreboard helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic chk_lsr(input string tag, input logic [7:0] rbr, input logic dr, input logic oe,
                          input logic pe, input logic fe, input logic bi);
      chk({tag, "_rbr"}, rbr_data, rbr);
      chk({tag, "_dr"}, data_ready, dr);
      chk({tag, "_oe"}, overrun_err, oe);
      chk({tag, "_pe"}, parity_err, pe);
      chk({tag, "_fe"}, framing_err, fe);
      chk({tag, "_bi"}, break_int, bi);
   endtask

   // ---------------- drivers ----------------
   task automatic send_bit(input logic b);
      srx = b;
      repeat (BIT_CLKS) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input int wl, input logic pen, input logic par,
                             input logic stop);
      send_bit(1'b0);
      for (int i = 0; i < wl; i++) send_bit(d[i]);
      if (pen) send_bit(par);
      send_bit(stop);
      send_bit(1'b1);
      send_bit(1'b1);
   endtask

   task automatic host_read(input logic r_rbr, input logic r_lsr);
      read_rbr = r_rbr;
      read_lsr = r_lsr;
      @(negedge clk);
      read_rbr = 1'b0;
      read_lsr = 1'b0;
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      srx = 1'b1;
      read_rbr = 1'b0;
      read_lsr = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   // ---------------- test ----------------
   initial begin
      int d0;
      logic       seen;
      logic [7:0] m_rbr;
      logic       m_dr, m_oe, m_pe, m_fe, m_bi;

      //            lcr    data   par   stop  rbr    pe    fe    bi
      vecs[0]  = '{8'h03, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{8'h1B, 8'h07, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0, 1'b0};
      vecs[2]  = '{8'h1B, 8'h07, 1'b0, 1'b1, 8'h07, 1'b1, 1'b0, 1'b0};
      vecs[3]  = '{8'h00, 8'h15, 1'b0, 1'b1, 8'h15, 1'b0, 1'b0, 1'b0};
      vecs[4]  = '{8'h02, 8'h7F, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b0, 1'b0};
      vecs[5]  = '{8'h03, 8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b0};
      vecs[6]  = '{8'h0B, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0};
      vecs[7]  = '{8'h01, 8'hFF, 1'b0, 1'b1, 8'h3F, 1'b0, 1'b0, 1'b0};
      vecs[8]  = '{8'h1A, 8'h55, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0};
      vecs[9]  = '{8'h0A, 8'h55, 1'b0, 1'b1, 8'h55, 1'b1, 1'b0, 1'b0};
      vecs[10] = '{8'hE3, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0};

      lcr = 8'h03;
      rst = 1'b1;
      srx = 1'b1;
      read_rbr = 1'b0;
      read_lsr = 1'b0;
      repeat (3) @(negedge clk);
      chk_lsr("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("reset_done", rx_done, 1'b0);
      chk("reset_busy", rx_busy, 1'b0);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      // Directed frame table
      for (int i = 0; i < NV; i++) begin
         host_read(1'b1, 1'b1);
         lcr = vecs[i].lcr;
         d0  = done_cnt;
         send_frame(vecs[i].data, 5 + int'(vecs[i].lcr[1:0]), vecs[i].lcr[3], vecs[i].par, vecs[i].stop);
         chk_lsr($sformatf("v%0d", i), vecs[i].exp_rbr, 1'b1, 1'b0, vecs[i].exp_pe,
                 vecs[i].exp_fe, vecs[i].exp_bi);
         chk($sformatf("v%0d_done", i), done_cnt - d0, 1);
         chk($sformatf("v%0d_lcr", i), dbg_lcr, vecs[i].lcr);
         chk($sformatf("v%0d_busy", i), rx_busy, 1'b0);
      end

      // Break: srx low for two frame times, then back high
      host_read(1'b1, 1'b1);
      lcr = 8'h03;
      d0  = done_cnt;
      srx = 1'b0;
      repeat (20 * BIT_CLKS) @(negedge clk);
      chk("brk_done_low", done_cnt - d0, 1);
      chk("brk_busy_low", rx_busy, 1'b0);
      srx = 1'b1;
      repeat (3 * BIT_CLKS) @(negedge clk);
      chk("brk_done_after", done_cnt - d0, 1);
      chk_lsr("brk", 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);

      // Overrun: two chars without reading RBR
      host_read(1'b1, 1'b1);
      d0 = done_cnt;
      send_frame(8'h11, 8, 1'b0, 1'b0, 1'b1);
      send_frame(8'h22, 8, 1'b0, 1'b0, 1'b1);
      chk("ovr_done", done_cnt - d0, 2);
      chk_lsr("ovr", 8'h11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      host_read(1'b0, 1'b1);
      chk_lsr("ovr_lsr", 8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      host_read(1'b1, 1'b0);
      chk("ovr_rbr_clr", data_ready, 1'b0);
      host_read(1'b1, 1'b0);
      chk("ovr_rbr_clr2", data_ready, 1'b0);

      // read_rbr landing in the completion cycle: new char loads, no overrun
      send_frame(8'h33, 8, 1'b0, 1'b0, 1'b1);
      chk("coinc_pre_dr", data_ready, 1'b1);
      seen = 1'b0;
      fork
         send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1);
         begin
            int n;
            n = 0;
            while (rx_done !== 1'b1 && n < 1500) begin
               @(negedge clk);
               n++;
            end
            if (rx_done === 1'b1) begin
               seen = 1'b1;
               read_rbr = 1'b1;
               @(negedge clk);
               read_rbr = 1'b0;
            end
         end
      join
      chk("coinc_seen", seen, 1'b1);
      chk_lsr("coinc", 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

      // Start-bit glitch: low for 4 ticks only
      d0  = done_cnt;
      srx = 1'b0;
      repeat (4 * TICK_DIV) @(negedge clk);
      srx = 1'b1;
      repeat (3 * BIT_CLKS) @(negedge clk);
      chk("glitch_done", done_cnt - d0, 0);
      chk("glitch_state", dbg_state, 3'd0);
      chk_lsr("glitch", 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

      // Reset in the middle of a frame
      srx = 1'b0;
      repeat (BIT_CLKS) @(negedge clk);
      srx = 1'b1;
      repeat (BIT_CLKS) @(negedge clk);
      srx = 1'b0;
      repeat (BIT_CLKS / 2) @(negedge clk);
      chk("mid_busy", rx_busy, 1'b1);
      host_read(1'b0, 1'b0);
      do_reset();
      chk_lsr("midrst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("midrst_state", dbg_state, 3'd0);
      repeat (4 * BIT_CLKS) @(negedge clk);
      chk("midrst_idle", rx_busy, 1'b0);

      // Random frames against the frame-level model
      do_reset();
      m_rbr = 8'h00;
      m_dr = 1'b0; m_oe = 1'b0; m_pe = 1'b0; m_fe = 1'b0; m_bi = 1'b0;
      for (int f = 0; f < 14; f++) begin
         logic rr, rl, pen, eps, p, stp, pe, fe, bi;
         logic [7:0] lc, dat, dm;
         int wl, ones;
         rr  = ($urandom_range(0, 2) != 0);
         rl  = ($urandom_range(0, 1) == 1);
         lc  = 8'($urandom_range(0, 255));
         dat = 8'($urandom_range(0, 255));
         p   = ($urandom_range(0, 1) == 1);
         stp = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 5) == 0) begin
            dat = 8'h00;
            p   = 1'b0;
            stp = 1'b0;
         end
         host_read(rr, rl);
         if (rr) m_dr = 1'b0;
         if (rl) begin
            m_oe = 1'b0; m_pe = 1'b0; m_fe = 1'b0; m_bi = 1'b0;
         end
         wl   = 5 + int'(lc[1:0]);
         pen  = lc[3];
         eps  = lc[4];
         dm   = dat & 8'((1 << wl) - 1);
         ones = $countones(dm);
         pe   = pen && (((ones + int'(p)) % 2) != (eps ? 0 : 1));
         fe   = !stp;
         bi   = (dm == 8'h00) && (!pen || !p) && !stp;
         lcr  = lc;
         d0   = done_cnt;
         send_frame(dat, wl, pen, p, stp);
         if (!m_dr) begin
            m_rbr = dm;
            m_dr  = 1'b1;
         end else begin
            m_oe = 1'b1;
         end
         m_pe = m_pe | pe;
         m_fe = m_fe | fe;
         m_bi = m_bi | bi;
         chk_lsr($sformatf("r%0d", f), m_rbr, m_dr, m_oe, m_pe, m_fe, m_bi);
         chk($sformatf("r%0d_done", f), done_cnt - d0, 1);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
